// File: rtl/rgb_led_fader.sv
// rgb_led_fader: turns an active-low RGB on/off pattern into per-channel PWM
// with programmable brightness and an optional linear cross-fade.
module rgb_led_fader #(
   parameter int PWM_BITS  = 8,
   parameter int STEP_CLKS = 12000
) (
   input  logic                CLK,
   input  logic                RST,
   input  logic [2:0]          LED_IN,
   input  logic [PWM_BITS-1:0] BRIGHT,
   input  logic                FADE_EN,
   output logic [2:0]          LED_OUT,
   output logic                BUSY,
   output logic                PWM_SYNC
);
   localparam int SW = (STEP_CLKS > 1) ? $clog2(STEP_CLKS) : 1;
   localparam logic [PWM_BITS-1:0] PWM_MAX = '1;
   localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CLKS - 1);

   logic [PWM_BITS-1:0] r_pwm_cnt;
   logic [SW-1:0]       r_step_cnt;
   logic                w_step_tick;
   logic [2:0]          w_on;
   logic [2:0]          w_diff;

   assign w_step_tick = r_step_cnt == STEP_LAST;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_pwm_cnt  <= '0;
         r_step_cnt <= '0;
         LED_OUT    <= 3'b111;
         BUSY       <= 1'b0;
         PWM_SYNC   <= 1'b0;
      end else begin
         r_pwm_cnt  <= r_pwm_cnt + 1'b1;
         r_step_cnt <= w_step_tick ? '0 : r_step_cnt + 1'b1;
         LED_OUT    <= ~w_on;
         BUSY       <= |w_diff;
         PWM_SYNC   <= r_pwm_cnt == '0;
      end
   end

   for (genvar i = 0; i < 3; i++) begin : g_ch
      logic [PWM_BITS-1:0] r_tgt, r_duty, r_act;
      // full scale is forced on so the top duty has no one-clock gap
      assign w_on[i]   = (r_act == PWM_MAX) || (r_pwm_cnt < r_act);
      assign w_diff[i] = r_duty != r_tgt;
      always_ff @(posedge CLK) begin
         if (RST) begin
            r_tgt  <= '0;
            r_duty <= '0;
            r_act  <= '0;
         end else begin
            r_tgt  <= LED_IN[i] ? '0 : BRIGHT;
            r_duty <= !FADE_EN              ? r_tgt :
                      !w_step_tick          ? r_duty :
                      (r_duty < r_tgt)      ? r_duty + 1'b1 :
                      (r_duty > r_tgt)      ? r_duty - 1'b1 : r_duty;
            // latch duty only at the period boundary so each period is uniform
            if (r_pwm_cnt == PWM_MAX) r_act <= r_duty;
         end
      end
   end
endmodule

// File: tb/tb_rgb_led_fader.sv
// tb_rgb_led_fader: directed checks of PWM output, fade ramps, redirect,
// abort and reset behaviour with PWM_BITS=4, STEP_CLKS=4.
module tb_rgb_led_fader;
   logic       CLK = 1'b0;
   logic       RST;
   logic [2:0] LED_IN;
   logic [3:0] BRIGHT;
   logic       FADE_EN;
   logic [2:0] LED_OUT;
   logic       BUSY;
   logic       PWM_SYNC;
   int         cyc = 0;
   int         n_chk = 0;
   int         n_pass = 0;
   int         n0;

   rgb_led_fader #(.PWM_BITS(4), .STEP_CLKS(4)) dut (
      .CLK(CLK), .RST(RST), .LED_IN(LED_IN), .BRIGHT(BRIGHT), .FADE_EN(FADE_EN),
      .LED_OUT(LED_OUT), .BUSY(BUSY), .PWM_SYNC(PWM_SYNC)
   );

   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= RST ? 0 : cyc + 1;

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
   endtask

   // expected pins at sample cycle c for given applied duties (pwm_cnt seen is c-1)
   function automatic logic [2:0] exp_led(input int ar, input int ag, input int ab, input int c);
      int p;
      p = (c - 1) % 16;
      return {!(ar == 15 || p < ar), !(ag == 15 || p < ag), !(ab == 15 || p < ab)};
   endfunction

   task automatic wait_align(input int m, input int r);
      @(negedge CLK);
      while (cyc % m != r) @(negedge CLK);
   endtask

   // steady FADE_EN=0 change applied at aligned n0; new duties reach pins after n0+16
   task automatic span(input int base, input int o_r, input int o_g, input int o_b,
                       input int n_r, input int n_g, input int n_b);
      while (cyc < base + 48) begin
         @(negedge CLK);
         chk("led", LED_OUT, cyc <= base + 16 ? exp_led(o_r, o_g, o_b, cyc) : exp_led(n_r, n_g, n_b, cyc));
         chk("sync", PWM_SYNC, (cyc - 1) % 16 == 0);
         if (cyc >= base + 3) chk("busy", BUSY, 0);
      end
   endtask

   initial begin
      RST = 1'b1; LED_IN = 3'b111; BRIGHT = 4'd15; FADE_EN = 1'b0;
      repeat (3) @(negedge CLK);
      chk("rst_led", LED_OUT, 3'b111);
      chk("rst_busy", BUSY, 0);
      chk("rst_sync", PWM_SYNC, 0);
      RST = 1'b0;
      for (int k = 0; k < 48; k++) begin
         @(negedge CLK);
         chk("idle_led", LED_OUT, 3'b111);
         chk("idle_busy", BUSY, 0);
         chk("idle_sync", PWM_SYNC, (cyc - 1) % 16 == 0);
      end
      n0 = cyc;
      LED_IN = 3'b011;
      span(n0, 0, 0, 0, 15, 0, 0);
      n0 = cyc;
      BRIGHT = 4'd5; LED_IN = 3'b101;
      span(n0, 15, 0, 0, 0, 5, 0);
      // fade up 0 -> 8
      LED_IN = 3'b111;
      wait_align(16, 0);
      n0 = cyc;
      FADE_EN = 1'b1; BRIGHT = 4'd8; LED_IN = 3'b110;
      while (cyc < n0 + 36) begin
         @(negedge CLK);
         chk("up_duty", dut.g_ch[0].r_duty, cyc < n0 + 4 ? 0 : ((cyc - n0) / 4 > 8 ? 8 : (cyc - n0) / 4));
         chk("up_busy", BUSY, cyc >= n0 + 2 && cyc <= n0 + 32);
      end
      // fade down 8 -> 0, no wrap
      wait_align(16, 0);
      n0 = cyc;
      LED_IN = 3'b111;
      while (cyc < n0 + 40) begin
         @(negedge CLK);
         chk("dn_duty", dut.g_ch[0].r_duty, cyc < n0 + 4 ? 8 : (8 - (cyc - n0) / 4 < 0 ? 0 : 8 - (cyc - n0) / 4));
         chk("dn_busy", BUSY, cyc >= n0 + 2 && cyc <= n0 + 32);
      end
      // redirect at duty 4 toward 2
      wait_align(16, 0);
      n0 = cyc;
      LED_IN = 3'b110;
      while (cyc < n0 + 16) begin
         @(negedge CLK);
         chk("rd_up_duty", dut.g_ch[0].r_duty, cyc < n0 + 4 ? 0 : (cyc - n0) / 4);
      end
      BRIGHT = 4'd2;
      while (cyc < n0 + 32) begin
         @(negedge CLK);
         chk("rd_duty", dut.g_ch[0].r_duty, cyc < n0 + 20 ? 4 : (cyc < n0 + 24 ? 3 : 2));
         chk("rd_busy", BUSY, cyc <= n0 + 24);
      end
      // abort fade: snap to new target
      FADE_EN = 1'b0; BRIGHT = 4'd10;
      while (cyc < n0 + 37) begin
         @(negedge CLK);
         chk("ab_duty", dut.g_ch[0].r_duty, cyc == n0 + 33 ? 2 : 10);
         if (cyc != n0 + 34) chk("ab_busy", BUSY, 0);
      end
      // reset mid-fade at duty 6, pwm_cnt 3
      LED_IN = 3'b111;
      wait_align(16, 8);
      n0 = cyc;
      FADE_EN = 1'b1; BRIGHT = 4'd8; LED_IN = 3'b110;
      while (cyc < n0 + 27) @(negedge CLK);
      chk("pre_duty", dut.g_ch[0].r_duty, 6);
      chk("pre_pwm", dut.r_pwm_cnt, 3);
      RST = 1'b1;
      @(negedge CLK);
      chk("mr_led", LED_OUT, 3'b111);
      chk("mr_busy", BUSY, 0);
      chk("mr_sync", PWM_SYNC, 0);
      chk("mr_pwm", dut.r_pwm_cnt, 0);
      chk("mr_step", dut.r_step_cnt, 0);
      chk("mr_duty", dut.g_ch[0].r_duty, 0);
      chk("mr_act", dut.g_ch[0].r_act, 0);
      RST = 1'b0; FADE_EN = 1'b0; LED_IN = 3'b111;
      @(negedge CLK);
      chk("post_sync", PWM_SYNC, 1);
      chk("post_led", LED_OUT, 3'b111);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/rgb_led_fader.md
Name: rgb_led_fader

Overview:
- Output stage between the traffic-signal controller's 3-bit active-low RGB pattern and the board RGB LED pins.
- Converts the on/off pattern into a per-channel PWM drive with programmable brightness.
- Optional linear cross-fade, so colour changes ramp instead of snapping.
- Single clock domain, same CLK as the controller (12 MHz board clock).

Parameters:
- PWM_BITS, 8: PWM counter and duty width; PWM period = 2^PWM_BITS clocks (256 clk = 46.9 kHz at 12 MHz).
- STEP_CLKS, 12000: clocks per fade step (one duty LSB per step; 1 ms at 12 MHz, so a full fade is 255 ms).

Ports:
- CLK  input  1  clock.
- RST  input  1  reset, synchronous, active-high.
- LED_IN  input  3  active-low colour pattern from the controller; bit 0 = blue, bit 1 = green, bit 2 = red; 0 = channel on.
- BRIGHT  input  PWM_BITS  target duty applied to every channel that is on.
- FADE_EN  input  1  1 = ramp duties, 0 = apply targets immediately.
- LED_OUT  output  3  active-low PWM drive to the LED pins, registered.
- BUSY  output  1  1 while any channel duty differs from its target, registered.
- PWM_SYNC  output  1  one-cycle pulse, registered; high in the cycle LED_OUT reflects pwm_cnt==0.

Behaviour:
- Reset state (RST=1 at a CLK edge):
  - pwm_cnt=0, step_cnt=0.
  - tgt[i]=0, duty[i]=0, act[i]=0.
  - LED_OUT=3'b111 (all off), BUSY=0, PWM_SYNC=0.
  - Reset mid-fade or mid-period discards all state immediately; no partial period is completed.
- Target register: every cycle, tgt[i] <= (LED_IN[i]==0) ? BRIGHT : 0. LED_IN and BRIGHT therefore take effect 1 cycle after sampling.
- PWM counter: pwm_cnt increments every cycle and wraps from 2^PWM_BITS-1 to 0.
- Step prescaler:
  - step_cnt runs 0..STEP_CLKS-1 and wraps.
  - step_tick=1 combinationally when step_cnt==STEP_CLKS-1.
  - Free-running; it is not restarted by pattern changes.
- Duty update:
  - FADE_EN=0: duty[i] <= tgt[i] every cycle.
  - FADE_EN=1, on step_tick: duty[i] moves one LSB toward tgt[i] (+1 if below, -1 if above, hold if equal). No overshoot and no wrap; the arithmetic is PWM_BITS wide.
  - FADE_EN=1 without step_tick: duty holds.
  - A target change mid-ramp (new LED_IN or BRIGHT) redirects the ramp from the current duty; nothing restarts from 0.
  - FADE_EN falling mid-ramp: duty snaps to tgt on the next cycle.
- Glitch-free apply:
  - act[i] <= duty[i] only in the cycle where pwm_cnt==2^PWM_BITS-1, so each period uses a single constant duty.
  - A duty change therefore reaches the pins at the next period boundary; worst case about 2^PWM_BITS+3 cycles from the LED_IN change.
- Output compare (registered, 1-cycle latency from pwm_cnt):
  - Channel on when act[i]==2^PWM_BITS-1 (full on, no gap); otherwise on when pwm_cnt < act[i].
  - act[i]=0 means fully off.
  - LED_OUT[i] = ~on.
  - On-time per period is act clocks, except full-scale, which is 2^PWM_BITS.
- BUSY <= |(duty[i] != tgt[i]) over all i. BUSY stays 0 for single-cycle mismatches while FADE_EN=0 only if tgt and duty already match; a 1-cycle BUSY pulse on an instant change is permitted.
- PWM_SYNC <= (pwm_cnt==0), registered alongside LED_OUT.
- No other state machine; the three channels are fully independent except for the shared counters.

Test Plan:
Bench uses PWM_BITS=4, STEP_CLKS=4 unless noted.
- Reset and idle:
  - Stimulus: hold RST 3 cycles, then LED_IN=3'b111, BRIGHT=15.
  - Required: LED_OUT=3'b111 forever, BUSY=0, PWM_SYNC pulses every 16 cycles.
- Instant full-on:
  - Stimulus: FADE_EN=0, BRIGHT=15, LED_IN=3'b011 (red).
  - Required: from the first period boundary after tgt updates, LED_OUT[2]=0 continuously and LED_OUT[1:0]=2'b11.
- Partial duty:
  - Stimulus: FADE_EN=0, BRIGHT=5, LED_IN=3'b101 (green).
  - Required: each 16-cycle period, LED_OUT[1] is 0 for exactly 5 cycles starting in the PWM_SYNC cycle.
- Fade up and down:
  - Stimulus: FADE_EN=1, BRIGHT=8, LED_IN goes 3'b111 -> 3'b110.
  - Required: duty[0] rises 0->8 in 8 step_ticks (32 clk); BUSY is high throughout and drops the cycle after duty reaches 8.
  - Then LED_IN=3'b111: duty[0] falls 8->0 in 32 clk, with no wrap below 0.
- Redirect and abort:
  - Stimulus: during a fade-up at duty 4, set BRIGHT=2.
  - Required: duty goes 4->3->2 and stops.
  - Then FADE_EN=0 with BRIGHT=10: duty=10 next cycle, BUSY=0 after that.
- Reset mid-fade:
  - Stimulus: assert RST while duty=6 and pwm_cnt=3.
  - Required: the next cycle shows LED_OUT=3'b111, BUSY=0, and all counters at 0.
